// File: rtl/multi_lane_accum_pkg.sv
// Shared types and helpers for multi_lane_accum.
//   state_t        : frame FSM states (accumulating / stalled on a full output)
//   osize_default  : lane-sum width that holds FRAME_LEN maximal samples
package multi_lane_accum_pkg;

  typedef enum logic {S_ACC, S_STALL} state_t;

  // Width of a lane sum that cannot overflow for FRAME_LEN beats of
  // DSIZE-bit unsigned samples.
  function automatic int osize_default(input int dsize, input int frame_len);
    return dsize + $clog2(frame_len);
  endfunction

endpackage

// File: rtl/multi_lane_accum_lane.sv
// accum_lane: one lane's running accumulator and sticky overflow flag.
//   clock, rst_n : clock / async active-low reset
//   clr          : synchronous clear (frame abort), beats the add
//   add_en       : accepted beat this cycle
//   last         : accepted beat closes the frame; accumulator restarts at 0
//   din          : lane sample
//   sum_next     : accumulator value including din (wrapped or clamped)
//   ovf_next     : sticky overflow including this beat's carry
module accum_lane #(
  parameter int DSIZE    = 8,
  parameter int OSIZE    = 12,
  parameter int SAT_MODE = 0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             add_en,
  input  logic             last,
  input  logic [DSIZE-1:0] din,
  output logic [OSIZE-1:0] sum_next,
  output logic             ovf_next
);

  logic [OSIZE-1:0] acc;
  logic             ovf;
  logic [OSIZE:0]   sum_wide;

  // One extra bit catches the carry-out that marks overflow.
  assign sum_wide = {1'b0, acc} + {{(OSIZE+1-DSIZE){1'b0}}, din};
  assign ovf_next = ovf | sum_wide[OSIZE];

  generate
    if (SAT_MODE != 0) begin : g_sat
      // Sticky flag keeps the clamp for the rest of the frame even when
      // later adds of zero would not carry.
      assign sum_next = ovf_next ? '1 : sum_wide[OSIZE-1:0];
    end else begin : g_wrap
      assign sum_next = sum_wide[OSIZE-1:0];
    end
  endgenerate

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (add_en) begin
      if (last) begin
        acc <= '0;
        ovf <= 1'b0;
      end else begin
        acc <= sum_next;
        ovf <= ovf_next;
      end
    end
  end

endmodule

// File: rtl/multi_lane_accum.sv
// multi_lane_accum: sums NCH unsigned lanes over FRAME_LEN accepted beats and
// presents all lane sums as one output beat.
//   clock, rst_n         : clock / async active-low reset
//   sclr                 : synchronous frame abort (pending output kept)
//   in_valid/in_ready    : input stream handshake
//   in_data              : lane k at [k*DSIZE +: DSIZE]
//   out_valid/out_ready  : output stream handshake
//   out_data             : lane k sum at [k*OSIZE +: OSIZE]
//   out_ovf              : per-lane overflow seen during the frame
//   beat_cnt             : beats accepted in the current frame
module multi_lane_accum
  import multi_lane_accum_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int NCH       = 4,
  parameter int FRAME_LEN = 16,
  parameter int OSIZE     = osize_default(DSIZE, FRAME_LEN),
  parameter int SAT_MODE  = 0
) (
  input  logic                         clock,
  input  logic                         rst_n,
  input  logic                         sclr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NCH*DSIZE-1:0]         in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NCH*OSIZE-1:0]         out_data,
  output logic [NCH-1:0]               out_ovf,
  output logic [$clog2(FRAME_LEN)-1:0] beat_cnt
);

  localparam int             CW   = $clog2(FRAME_LEN);
  localparam logic [CW-1:0]  LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  state_t                      state_q, state_d;
  logic                        last_pos;
  logic                        blocked;
  logic                        accept;
  logic                        frame_done;
  logic [NCH-1:0][OSIZE-1:0]   lane_sum;
  logic [NCH-1:0]              lane_ovf;

  assign last_pos = (beat_cnt == LAST);
  // The closing beat may only enter when the output register is empty or
  // being drained this same cycle; that gives back-to-back frames.
  assign blocked    = last_pos && out_valid && !out_ready;
  assign in_ready   = !blocked;
  assign accept     = in_valid && in_ready;
  assign frame_done = accept && last_pos && !sclr;

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_lane
      accum_lane #(
        .DSIZE    (DSIZE),
        .OSIZE    (OSIZE),
        .SAT_MODE (SAT_MODE)
      ) u_lane (
        .clock    (clock),
        .rst_n    (rst_n),
        .clr      (sclr),
        .add_en   (accept),
        .last     (last_pos),
        .din      (in_data[k*DSIZE +: DSIZE]),
        .sum_next (lane_sum[k]),
        .ovf_next (lane_ovf[k])
      );
    end
  endgenerate

  // S_STALL marks a finished frame waiting on the output register; the
  // handshake itself is fully described by in_ready above.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC:   if (!sclr && blocked) state_d = S_STALL;
      S_STALL: if (sclr || out_ready) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_ACC;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= '0;
    end else begin
      state_q <= state_d;

      if (sclr)        beat_cnt <= '0;
      else if (accept) beat_cnt <= last_pos ? '0 : beat_cnt + ONE;

      if (frame_done) begin
        out_valid <= 1'b1;
        out_data  <= lane_sum;
        out_ovf   <= lane_ovf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multi_lane_accum.sv
module tb_multi_lane_accum;
  localparam int DS = 8, NC = 4, FL = 16, OS = 12;
  localparam longint OMOD = longint'(1) << OS;

  typedef struct {
    logic [NC*OS-1:0] d;
    logic [NC-1:0]    o;
  } res_t;

  logic clock = 1'b0, rst_n = 1'b0, sclr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [NC*DS-1:0] in_data = '0;
  logic             in_ready, out_valid;
  logic [NC*OS-1:0] out_data;
  logic [NC-1:0]    out_ovf;
  logic [3:0]       beat_cnt;

  // two small frames (FRAME_LEN=4, OSIZE=8) for wrap vs saturate
  logic        s_valid = 1'b0;
  logic [15:0] s_data  = '0;
  logic        w_ir, w_ov, t_ir, t_ov;
  logic [15:0] w_d, t_d;
  logic [1:0]  w_o, t_o, w_bc, t_bc;

  always #5 clock = ~clock;

  multi_lane_accum #(.DSIZE(DS), .NCH(NC), .FRAME_LEN(FL)) dut (
    .clock(clock), .rst_n(rst_n), .sclr(sclr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .beat_cnt(beat_cnt));

  multi_lane_accum #(.DSIZE(8), .NCH(2), .FRAME_LEN(4), .OSIZE(8), .SAT_MODE(0)) dut_wrap (
    .clock(clock), .rst_n(rst_n), .sclr(1'b0), .in_valid(s_valid), .in_ready(w_ir),
    .in_data(s_data), .out_valid(w_ov), .out_ready(1'b1), .out_data(w_d),
    .out_ovf(w_o), .beat_cnt(w_bc));

  multi_lane_accum #(.DSIZE(8), .NCH(2), .FRAME_LEN(4), .OSIZE(8), .SAT_MODE(1)) dut_sat (
    .clock(clock), .rst_n(rst_n), .sclr(1'b0), .in_valid(s_valid), .in_ready(t_ir),
    .in_data(s_data), .out_valid(t_ov), .out_ready(1'b1), .out_data(t_d),
    .out_ovf(t_o), .beat_cnt(t_bc));

  int checks = 0, failures = 0;
  res_t expq[$];
  longint tsum[NC];
  int cnt_m = 0, taken = 0, stall_cycles = 0;
  bit hold_v = 1'b0, reached;
  logic [NC*OS-1:0] hold_d;
  logic [NC-1:0]    hold_o;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NC; k++) tsum[k] = 0;
    cnt_m = 0;
  endtask

  // Reference: true lane sums, reduced modulo 2^OS at frame end.
  task automatic model_accept(input logic [NC*DS-1:0] d);
    res_t r;
    for (int k = 0; k < NC; k++) tsum[k] += longint'(d[k*DS +: DS]);
    cnt_m++;
    if (cnt_m == FL) begin
      for (int k = 0; k < NC; k++) begin
        r.d[k*OS +: OS] = OS'(tsum[k] % OMOD);
        r.o[k]          = (tsum[k] >= OMOD);
      end
      expq.push_back(r);
      model_clear();
    end
  endtask

  // One clock: sample at negedge, update model, return #1 after posedge.
  task automatic step();
    res_t e;
    @(negedge clock);
    chk("out_valid", out_valid, expq.size() != 0);
    chk("beat_cnt", beat_cnt, cnt_m);
    if (out_valid) begin
      if (hold_v) begin
        chk("hold_data", out_data, hold_d);
        chk("hold_ovf", out_ovf, hold_o);
      end
      if (out_ready) begin
        hold_v = 1'b0;
        if (expq.size() != 0) begin
          e = expq.pop_front();
          taken++;
          chk("out_data", out_data, e.d);
          chk("out_ovf", out_ovf, e.o);
        end
      end else begin
        hold_v = 1'b1;
        hold_d = out_data;
        hold_o = out_ovf;
      end
    end else hold_v = 1'b0;
    if (sclr) model_clear();
    else if (in_valid && in_ready) model_accept(in_data);
    @(posedge clock);
    #1;
  endtask

  function automatic logic [NC*DS-1:0] rnd_beat();
    logic [NC*DS-1:0] v;
    for (int k = 0; k < NC; k++) v[k*DS +: DS] = DS'($urandom);
    return v;
  endfunction

  initial begin
    int t0;
    model_clear();

    // reset values
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_small_valid", {w_ov, t_ov}, 0);
    @(negedge clock) rst_n = 1'b1;
    @(posedge clock); #1;

    // wrap vs saturate: 4 beats of 0x80 into 8-bit sums
    s_valid = 1'b1; s_data = 16'h8080;
    chk("small_ready", {w_ir, t_ir}, 2'b11);
    repeat (4) begin @(posedge clock); #1; end
    s_valid = 1'b0;
    chk("wrap_valid", w_ov, 1);
    chk("wrap_data", w_d, 16'h0000);
    chk("wrap_ovf", w_o, 2'b11);
    chk("sat_valid", t_ov, 1);
    chk("sat_data", t_d, 16'hFFFF);
    chk("sat_ovf", t_o, 2'b11);
    chk("wrap_bc", w_bc, 0);

    // every lane = 1 for one frame, 1-cycle latency
    out_ready = 1'b1;
    in_data = {NC{8'd1}};
    for (int i = 0; i < FL; i++) begin
      in_valid = 1'b1;
      if (i == FL - 1) chk("lat_pre", out_valid, 0);
      step();
    end
    in_valid = 1'b0;
    chk("lat_valid", out_valid, 1);
    chk("ones_data", out_data, {NC{12'd16}});
    chk("ones_ovf", out_ovf, 0);
    step();
    step();

    // stall: out_ready low across two frames
    out_ready = 1'b0; in_valid = 1'b1; reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      in_data = rnd_beat();
      step();
      reached = (expq.size() == 1 && cnt_m == FL - 1);
    end
    chk("stall_reach", reached, 1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_beat_cnt", beat_cnt, FL - 1);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4 && cnt_m != 0; i++) step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("stall_drain", expq.size(), 0);

    // back-to-back: 3 frames of incrementing data, no bubbles
    out_ready = 1'b1; in_valid = 1'b1; t0 = taken; stall_cycles = 0;
    for (int n = 0; n < 3*FL; n++) begin
      for (int k = 0; k < NC; k++) in_data[k*DS +: DS] = DS'(n*NC + k);
      stall_cycles += (in_ready ? 0 : 1);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    chk("b2b_bubbles", stall_cycles, 0);
    chk("b2b_frames", taken - t0, 3);

    // sclr on beat 7 with in_valid high
    in_valid = 1'b1; t0 = taken;
    for (int i = 0; i < 7; i++) begin in_data = rnd_beat(); step(); end
    sclr = 1'b1; in_data = rnd_beat();
    step();
    sclr = 1'b0;
    chk("sclr_beat_cnt", beat_cnt, 0);
    for (int i = 0; i < FL; i++) begin in_data = rnd_beat(); step(); end
    in_valid = 1'b0;
    step(); step();
    chk("sclr_frames", taken - t0, 1);

    // random valid/ready gaps with occasional sclr
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      sclr      = ($urandom_range(63) == 0);
      in_data   = rnd_beat();
      step();
    end
    sclr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    chk("rand_drain", expq.size(), 0);

    // async reset in the middle of a stall
    out_ready = 1'b0; in_valid = 1'b1; reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      in_data = rnd_beat();
      step();
      reached = (expq.size() == 1 && cnt_m == FL - 1);
    end
    chk("rst_stall_reach", reached, 1);
    @(posedge clock); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_beat_cnt", beat_cnt, 0);
    expq.delete(); model_clear(); hold_v = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock) rst_n = 1'b1;
    @(posedge clock); #1;
    t0 = taken; in_valid = 1'b1;
    for (int i = 0; i < FL; i++) begin in_data = rnd_beat(); step(); end
    in_valid = 1'b0;
    step(); step();
    chk("post_rst_frames", taken - t0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_lane_accum.md
Name: multi_lane_accum

Overview:
- Parametrised successor to the single-lane "register an add" example block.
- Accumulates NCH parallel unsigned lanes over a frame of FRAME_LEN accepted input beats, then emits all NCH sums as one output beat.
- Input and output are valid/ready streams; the block back-pressures when a finished frame cannot be handed off.
- Sits between a sample producer and a downstream stats/report stage.

Parameters:
- DSIZE, 8, width of one input lane sample (unsigned).
- NCH, 4, number of parallel lanes (>=1).
- FRAME_LEN, 16, input beats per frame (>=2).
- OSIZE, DSIZE+$clog2(FRAME_LEN), width of one output lane sum.
- SAT_MODE, 0, overflow handling: 0 = wrap modulo 2^OSIZE, 1 = saturate to 2^OSIZE-1.

Ports:
- clock, input, 1, single clock; all logic on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- sclr, input, 1, synchronous frame abort/clear.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, block can accept a beat.
- in_data, input, NCH*DSIZE, lane k at bits [k*DSIZE +: DSIZE].
- out_valid, output, 1, result frame valid.
- out_ready, input, 1, downstream accepts the result.
- out_data, output, NCH*OSIZE, lane k sum at [k*OSIZE +: OSIZE].
- out_ovf, output, NCH, per-lane flag: the true sum exceeded 2^OSIZE-1 during the frame.
- beat_cnt, output, $clog2(FRAME_LEN), beats accepted in the current frame.

Behaviour:
- Clock and reset: one clock, `clock`; reset `rst_n` is asynchronous, active-low. All flops clear on reset.
- Reset values:
  - acc = 0, beat_cnt = 0, out_valid = 0, out_data = 0, out_ovf = 0, in_ready = 1, state = S_ACC.
- Handshakes:
  - Input beat accepted when in_valid && in_ready.
  - Output beat taken when out_valid && out_ready.
  - out_data and out_ovf are stable while out_valid && !out_ready.
- State machine:
  - S_ACC: accepting beats.
    - Non-last beat: acc[k] += lane k; beat_cnt++.
    - Last beat (beat_cnt == FRAME_LEN-1) with output register free or being taken this cycle:
      - out_data <= final sums; out_ovf <= flags; out_valid <= 1 at the next edge (1-cycle latency from the last beat).
      - acc <= 0, beat_cnt <= 0; stay in S_ACC.
    - beat_cnt == FRAME_LEN-1 while out_valid && !out_ready: go to S_STALL.
  - S_STALL: in_ready = 0. Go to S_ACC on the cycle out_ready is seen.
- in_ready (combinational): !(beat_cnt == FRAME_LEN-1 && out_valid && !out_ready).
  - Last beat and output take in the same cycle: both proceed, giving a back-to-back frame with no bubble.
- Arithmetic:
  - Each lane uses an OSIZE+1-bit add.
  - Carry-out sets the lane's sticky ovf.
  - SAT_MODE=1: clamp to all-ones once ovf is set, and hold the clamp for the rest of the frame.
  - SAT_MODE=0: keep the low OSIZE bits.
- sclr:
  - Zeroes acc, beat_cnt and the sticky flags; returns to S_ACC.
  - Does not drop a pending out_valid beat.
  - sclr together with an accepted beat: sclr wins and the beat is discarded.
- Reset mid-frame or mid-stall: all state lost, out_valid drops immediately (asynchronous).

Decomposition:
- Package multi_lane_accum_pkg:
  - typedef enum logic {S_ACC, S_STALL} state_t.
  - localparam function to compute the default OSIZE.
- Sub-module accum_lane (DSIZE, OSIZE, SAT_MODE):
  - Holds one lane's accumulator and sticky ovf.
  - Inputs: clock, rst_n, clr, add_en, last, din.
  - Outputs: sum_next, ovf_next.
  - Instantiated NCH times in a generate loop.
- Top level: FSM, beat counter, output register.

Test Plan:
- Defaults, every lane = 1 for 16 beats, out_ready=1 → one out beat, each lane = 16, out_ovf = 0, out_valid exactly 1 cycle after the 16th accept.
- DSIZE=8, FRAME_LEN=4, OSIZE=8, all lanes = 0x80, SAT_MODE=0 → sums 0x00, ovf=1; same stimulus with SAT_MODE=1 → sums 0xFF, ovf=1.
- Hold out_ready=0 across two full frames → second frame stalls with in_ready=0 at beat_cnt=15; first result stays stable; raising out_ready releases the stall, and the second result follows with correct sums.
- Last beat and output take in the same cycle, continuous in_valid → no idle cycle between frames; 3 consecutive frames of incrementing data match the model.
- sclr at beat 7 with in_valid=1 → that beat discarded, beat_cnt=0; the next 16 beats yield sums of those beats only.
- rst_n asserted low mid-stall → out_valid=0 and in_ready=1 asynchronously; after release, a fresh frame sums correctly.
